// File: rtl/vga_text_pkg.sv
// Shared text-mode overlay constants: scan coordinate widths, text grid size and ASCII codes.
package vga_text_pkg;

  localparam int unsigned ROW_W     = 5;
  localparam int unsigned COL_W     = 7;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;

  localparam logic [CHAR_W-1:0] ASCII_0   = 8'h30;
  localparam logic [CHAR_W-1:0] ASCII_A   = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_NUL = 8'h00;

  // Number of hex digits needed to show a w-bit word.
  function automatic int unsigned hex_digits(input int unsigned w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_digit_ascii.sv
// Combinational 4-bit value to ASCII hex digit ('0'-'9', 'A'-'F').
module hex_digit_ascii
  import vga_text_pkg::*;
(
  input  logic [3:0]        nibble,
  output logic [CHAR_W-1:0] ascii_c
);

  always_comb begin
    ascii_c = ASCII_NUL;
    if (nibble < 4'd10) ascii_c = ASCII_0 + CHAR_W'(nibble);
    else                ascii_c = ASCII_A + CHAR_W'(nibble - 4'd10);
  end

endmodule

// File: rtl/word_string_display.sv
// Tear-free overlay cell printing a WIDTH-bit word in binary or hex at (ROW,COL); the display
// only updates at frame_start and recently changed digits are flagged on highlight.
module word_string_display
  import vga_text_pkg::*;
#(
  parameter int unsigned ROW       = 0,
  parameter int unsigned COL       = 0,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HL_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic              enable,
  input  logic              mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  data,
  input  logic              frame_start,
  output logic              char_p,
  output logic [CHAR_W-1:0] char,
  output logic              highlight
);

  localparam int unsigned N_HEX = hex_digits(WIDTH);
  localparam int unsigned PAD_W = 4 * N_HEX;

  logic [WIDTH-1:0]  staged_q, staged_d, shown_q, shown_d, chg_mask_q, chg_mask_d;
  logic              pending_q, pending_d;
  logic [7:0]        hl_cnt_q, hl_cnt_d;
  logic              char_p_q, char_p_d, highlight_q, highlight_d;
  logic [CHAR_W-1:0] char_q, char_d;

  logic [WIDTH-1:0]  commit_word, diff;
  logic              do_commit;
  logic [COL_W-1:0]  col_lo, dig, n_digits;
  logic              hit;
  logic [PAD_W-1:0]  shown_pad, mask_pad;
  logic [3:0]        nib;
  logic              dig_hl;
  logic [CHAR_W-1:0] ascii_c;

  // Staging, frame-synchronous commit and highlight aging
  always_comb begin
    staged_d    = staged_q;
    pending_d   = pending_q;
    shown_d     = shown_q;
    chg_mask_d  = chg_mask_q;
    hl_cnt_d    = hl_cnt_q;
    commit_word = load ? data : staged_q;
    diff        = shown_q ^ commit_word;
    do_commit   = frame_start && (pending_q || load);

    if (load) staged_d = data;
    if (frame_start) pending_d = 1'b0;
    else if (load)   pending_d = 1'b1;
    if (do_commit) shown_d = commit_word;

    if (do_commit && (diff != '0)) begin
      chg_mask_d = ((hl_cnt_q != 8'd0) ? chg_mask_q : '0) | diff;
      hl_cnt_d   = 8'(HL_FRAMES);
    end else if (frame_start && (hl_cnt_q != 8'd0)) begin
      hl_cnt_d = hl_cnt_q - 8'd1;
      if (hl_cnt_q == 8'd1) chg_mask_d = '0;
    end
  end

  // Hit test; col < COL is rejected before the subtraction is trusted
  always_comb begin
    col_lo   = COL_W'(COL);
    n_digits = mode ? COL_W'(N_HEX) : COL_W'(WIDTH);
    dig      = col - col_lo;
    hit      = enable && (row == ROW_W'(ROW)) && (col >= col_lo) && (dig < n_digits);
  end

  // Digit select, leftmost digit holds the most significant bits
  always_comb begin
    shown_pad = PAD_W'(shown_q);
    mask_pad  = PAD_W'(chg_mask_q);
    nib       = 4'd0;
    dig_hl    = 1'b0;
    if (mode) begin
      for (int i = 0; i < int'(N_HEX); i++) begin
        if (dig == COL_W'(i)) begin
          nib    = shown_pad[4*(int'(N_HEX)-1-i) +: 4];
          dig_hl = |mask_pad[4*(int'(N_HEX)-1-i) +: 4];
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (dig == COL_W'(i)) begin
          nib    = {3'b000, shown_q[int'(WIDTH)-1-i]};
          dig_hl = chg_mask_q[int'(WIDTH)-1-i];
        end
      end
    end
  end

  hex_digit_ascii u_hex_digit_ascii (
    .nibble  (nib),
    .ascii_c (ascii_c)
  );

  always_comb begin
    char_p_d    = hit;
    char_d      = hit ? ascii_c : ASCII_NUL;
    highlight_d = hit && (hl_cnt_q != 8'd0) && dig_hl;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staged_q    <= '0;
      shown_q     <= '0;
      chg_mask_q  <= '0;
      pending_q   <= 1'b0;
      hl_cnt_q    <= 8'd0;
      char_p_q    <= 1'b0;
      char_q      <= ASCII_NUL;
      highlight_q <= 1'b0;
    end else begin
      staged_q    <= staged_d;
      shown_q     <= shown_d;
      chg_mask_q  <= chg_mask_d;
      pending_q   <= pending_d;
      hl_cnt_q    <= hl_cnt_d;
      char_p_q    <= char_p_d;
      char_q      <= char_d;
      highlight_q <= highlight_d;
    end
  end

  assign char_p    = char_p_q;
  assign char      = char_q;
  assign highlight = highlight_q;

endmodule
